id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 38 +++
 rtl/id_ex_hazard_detect.sv | 23 ++
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline register: width defaults,
// control-word bit positions and a packed view of the control word.
package id_ex_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_CTRL_W = 10;

    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_REG_DST    = 5;
    localparam int unsigned CTRL_BRANCH     = 6;
    localparam int unsigned CTRL_JUMP       = 7;
    localparam int unsigned CTRL_ALU_OP_LSB = 8;

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       jump;
        logic       branch;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_word_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the
// instruction currently in decode. Purely combinational.
module id_ex_hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    output logic             hazard_o
);

    logic rt_nonzero;
    logic rt_match;

    // Register $0 is hard-wired, so a load targeting it never creates a dependency.
    assign rt_nonzero = (ex_rt_i != '0);
    assign rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
    assign hazard_o   = id_valid_i && ex_valid_i && ex_mem_read_i && rt_nonzero && rt_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, downstream stall, load-use bubble
// insertion and a saturating bubble counter.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_data_a,
    input  logic [DATA_W-1:0] id_data_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [5:0]        id_funct,
    input  logic [25:0]       id_jtarget,
    input  logic              ex_flush,
    input  logic              ex_stall,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_data_a,
    output logic [DATA_W-1:0] ex_data_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [5:0]        ex_funct,
    output logic [25:0]       ex_jtarget,
    output logic [15:0]       bubble_count
);

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [REG_W-1:0]  rs_q,      rs_d;
    logic [REG_W-1:0]  rt_q,      rt_d;
    logic [REG_W-1:0]  rd_q,      rd_d;
    logic [DATA_W-1:0] data_a_q,  data_a_d;
    logic [DATA_W-1:0] data_b_q,  data_b_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [5:0]        funct_q,   funct_d;
    logic [25:0]       jtarget_q, jtarget_d;
    logic [CNT_W-1:0]  bubble_q,  bubble_d;
    logic              hazard;

    id_ex_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
        .ex_rt_i       (rt_q),
        .hazard_o      (hazard)
    );

    // A flush already squashes the decode slot, so it never needs to freeze fetch.
    assign stall_if_id = reset && !ex_flush && (ex_stall || hazard);

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        imm_d     = imm_q;
        funct_d   = funct_q;
        jtarget_d = jtarget_q;
        bubble_d  = bubble_q;
        if (ex_flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (ex_stall) begin
            // hold everything
        end else if (hazard) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            bubble_d = sat_inc(bubble_q);
        end else begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? id_ctrl : '0;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            data_a_d  = id_data_a;
            data_b_d  = id_data_b;
            imm_d     = id_imm;
            funct_d   = id_funct;
            jtarget_d = id_jtarget;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            imm_q     <= '0;
            funct_q   <= '0;
            jtarget_q <= '0;
            bubble_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            imm_q     <= imm_d;
            funct_q   <= funct_d;
            jtarget_q <= jtarget_d;
            bubble_q  <= bubble_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_data_a    = data_a_q;
    assign ex_data_b    = data_b_q;
    assign ex_imm       = imm_q;
    assign ex_funct     = funct_q;
    assign ex_jtarget   = jtarget_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each edge's
// EX-side state, which is queued and compared after the edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_data_a, id_data_b, id_imm;
    logic [5:0]  id_funct;
    logic [25:0] id_jtarget;
    logic        ex_flush, ex_stall;
    logic        stall_if_id;
    logic        ex_valid;
    logic [9:0]  ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_data_a, ex_data_b, ex_imm;
    logic [5:0]  ex_funct;
    logic [25:0] ex_jtarget;
    logic [15:0] bubble_count;

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_data_a    (id_data_a),
        .id_data_b    (id_data_b),
        .id_imm       (id_imm),
        .id_funct     (id_funct),
        .id_jtarget   (id_jtarget),
        .ex_flush     (ex_flush),
        .ex_stall     (ex_stall),
        .stall_if_id  (stall_if_id),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_data_a    (ex_data_a),
        .ex_data_b    (ex_data_b),
        .ex_imm       (ex_imm),
        .ex_funct     (ex_funct),
        .ex_jtarget   (ex_jtarget),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [9:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [5:0]  funct;
        logic [25:0] jt;
        logic [15:0] bub;
    } exp_t;

    localparam logic [9:0] LW  = 10'h01B;  // reg_write|mem_read|mem_to_reg|alu_src
    localparam logic [9:0] ADD = 10'h221;  // reg_write|reg_dst|alu_op=2

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 32'(ex_valid), 32'd0);
        check_val({tag, "_ctrl"}, 32'(ex_ctrl), 32'd0);
        check_val({tag, "_regs"}, 32'({ex_rs, ex_rt, ex_rd}), 32'd0);
        check_val({tag, "_data_a"}, ex_data_a, 32'd0);
        check_val({tag, "_data_b"}, ex_data_b, 32'd0);
        check_val({tag, "_imm"}, ex_imm, 32'd0);
        check_val({tag, "_funct_jt"}, 32'({ex_funct, ex_jtarget}), 32'd0);
        check_val({tag, "_bubbles"}, 32'(bubble_count), 32'd0);
        check_val({tag, "_stall"}, 32'(stall_if_id), 32'd0);
    endtask

    task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] a);
        id_valid   = v;
        id_ctrl    = c;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_data_a  = a;
        id_data_b  = $urandom;
        id_imm     = $urandom;
        id_funct   = 6'($urandom);
        id_jtarget = 26'($urandom);
    endtask

    // Predict one edge, check the combinational stall, then compare after the edge.
    task automatic step();
        exp_t e;
        logic haz;
        logic exp_stall;
        #1;
        haz = id_valid && m.valid && m.ctrl[1] && (m.rt != 5'd0) &&
              (m.rt == id_rs || m.rt == id_rt);
        exp_stall = !ex_flush && (ex_stall || haz);
        check_val("stall_if_id", 32'(stall_if_id), 32'(exp_stall));
        if (ex_flush) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
        end else if (ex_stall) begin
            m.valid = m.valid;
        end else if (haz) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
            if (m.bub != 16'hFFFF) m.bub = m.bub + 16'd1;
        end else begin
            m.valid = id_valid;
            m.ctrl  = id_valid ? id_ctrl : 10'd0;
            m.rs    = id_rs;
            m.rt    = id_rt;
            m.rd    = id_rd;
            m.a     = id_data_a;
            m.b     = id_data_b;
            m.imm   = id_imm;
            m.funct = id_funct;
            m.jt    = id_jtarget;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("ex_valid", 32'(ex_valid), 32'(e.valid));
        check_val("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        check_val("ex_regs", 32'({ex_rs, ex_rt, ex_rd}), 32'({e.rs, e.rt, e.rd}));
        check_val("ex_data_a", ex_data_a, e.a);
        check_val("ex_data_b", ex_data_b, e.b);
        check_val("ex_imm", ex_imm, e.imm);
        check_val("ex_funct", 32'(ex_funct), 32'(e.funct));
        check_val("ex_jtarget", 32'(ex_jtarget), 32'(e.jt));
        check_val("bubble_count", 32'(bubble_count), 32'(e.bub));
    endtask

    initial begin
        m        = '0;
        reset    = 1'b0;
        ex_flush = 1'b0;
        ex_stall = 1'b0;
        drive(1'b1, 10'h3FF, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF);
        #2;
        check_all_zero("reset_pre_clk");
        @(negedge clk);
        reset = 1'b1;

        // Load-use: one bubble, then the dependent instruction is captured.
        drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 32'h100);
        step();
        drive(1'b1, ADD, 5'd5, 5'd6, 5'd7, 32'h200);
        step();
        check_val("lu_stalled_bubbles", 32'(bubble_count), 32'd1);
        check_val("lu_ex_valid", 32'(ex_valid), 32'd0);
        step();
        check_val("lu_captured", ex_data_a, 32'h200);

        // $0 destination never stalls.
        drive(1'b1, LW, 5'd2, 5'd0, 5'd0, 32'h300);
        step();
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd8, 32'h400);
        step();
        check_val("zero_reg_bubbles", 32'(bubble_count), 32'd1);

        // Flush beats hazard.
        drive(1'b1, LW, 5'd2, 5'd9, 5'd0, 32'h500);
        step();
        drive(1'b1, ADD, 5'd9, 5'd3, 5'd4, 32'h600);
        ex_flush = 1'b1;
        step();
        ex_flush = 1'b0;
        check_val("flush_bubbles", 32'(bubble_count), 32'd1);

        // Downstream stall holds for three edges, then captures the waiting operand.
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3, 32'hAAAA5555);
        step();
        drive(1'b1, ADD, 5'd4, 5'd5, 5'd6, 32'h12345678);
        ex_stall = 1'b1;
        repeat (3) step();
        check_val("stall_hold_a", ex_data_a, 32'hAAAA5555);
        ex_stall = 1'b0;
        step();
        check_val("stall_release_a", ex_data_a, 32'h12345678);

        // Mixed traffic with small register range to provoke hazards.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? LW : 10'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), $urandom);
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 7) == 0);
            step();
        end
        ex_flush = 1'b0;
        ex_stall = 1'b0;

        // Asynchronous reset mid-stream, then a normal load on the first edge after release.
        drive(1'b1, LW, 5'd1, 5'd7, 5'd0, 32'h700);
        step();
        drive(1'b1, ADD, 5'd7, 5'd7, 5'd1, 32'h800);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("reset_async");
        m = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        check_val("post_reset_load", ex_data_a, 32'h800);

        // Saturation: preload the counter, then two more load-use bubbles.
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        force dut.bubble_q = 16'hFFFE;
        m.bub = 16'hFFFE;
        step();
        release dut.bubble_q;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, LW, 5'd1, 5'd10, 5'd0, 32'h900);
            step();
            drive(1'b1, ADD, 5'd10, 5'd2, 5'd3, 32'hA00);
            step();
        end
        check_val("saturated", 32'(bubble_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
